pipe_stage_hs: RTL

//  Parametrised inter-stage pipeline register with a valid/ready handshake, flush and bubble gating.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_sat_counter.sv | 25 ++
 rtl/pipe_stage_hs.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and types for the pipeline stage register
// Purpose: control-bit indices carried in the ctrl field, and the occupancy
//          states used by the two-entry skid buffer variant of pipe_stage_hs.
// Ports:   none (package)
package pipe_pkg;

  // Bit positions inside the control vector
  localparam int CTRL_WREG = 0;  // write destination register
  localparam int CTRL_RMEM = 1;  // memory read
  localparam int CTRL_WMEM = 2;  // memory write

  // Occupancy of the skid-buffered stage
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter
// Purpose: counts cycles where inc is high; sticks at all-ones instead of wrapping.
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous reset, active-low; clears count
//   inc    in   1      count this cycle
//   count  out  WIDTH  current count
module pipe_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// rtl/pipe_stage_hs.sv - valid/ready pipeline stage register with flush and bubble gating
// Purpose: holds one (or, with SKID_BUF_EN defined, two) pipeline entries between
//          stages. Stalls are back-pressure on out_ready. Bubbles present ctrl=0.
//          Counts cycles where a held entry is blocked by the downstream stage.
// Config macro: SKID_BUF_EN - when defined, two-entry skid buffer with a registered
//          in_ready; when undefined, single entry with in_ready = ~out_valid | out_ready.
// Ports:
//   clk         in   1            rising-edge clock
//   rst         in   1            asynchronous reset, active-low
//   flush       in   1            drop held and incoming entries at this edge
//   in_valid    in   1            upstream entry valid
//   in_ready    out  1            stage can accept this cycle
//   in_rd       in   RD_W         destination register
//   in_ctrl     in   CTRL_W       control vector
//   in_result   in   DATA_W       ALU result / address
//   in_wdata    in   DATA_W       store data
//   out_valid   out  1            head entry valid
//   out_ready   in   1            downstream accepts (0 = stall)
//   out_rd      out  RD_W         head rd
//   out_ctrl    out  CTRL_W       head ctrl, zero when out_valid=0
//   out_result  out  DATA_W       head result
//   out_wdata   out  DATA_W       head store data
//   stall_cnt   out  STALL_CNT_W  saturating count of out_valid & ~out_ready cycles
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int RD_W        = 5,
  parameter int CTRL_W      = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RD_W-1:0]        in_rd,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_result,
  input  logic [DATA_W-1:0]      in_wdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RD_W-1:0]        out_rd,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_result,
  output logic [DATA_W-1:0]      out_wdata,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int PAY_W = RD_W + CTRL_W + 2 * DATA_W;

  logic [PAY_W-1:0]  in_pay;
  logic [PAY_W-1:0]  head_q;
  logic [CTRL_W-1:0] head_ctrl;

  assign in_pay = {in_rd, in_ctrl, in_result, in_wdata};

`ifdef SKID_BUF_EN

  stage_state_e     state_q, state_d;
  logic [PAY_W-1:0] skid_q;
  logic             in_ready_q;
  logic             push, pop;
  logic             head_load, head_from_skid, skid_load;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      // Registered so upstream never sees a combinational path from out_ready
      in_ready_q <= (state_d != FULL);
    end
  end

  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d   = ONE;
            head_load = 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (!push && pop) begin
            state_d = EMPTY;
          end else if (push && pop) begin
            head_load = 1'b1;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can happen
          if (pop) begin
            state_d        = ONE;
            head_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (head_load) begin
        head_q <= in_pay;
      end else if (head_from_skid) begin
        head_q <= skid_q;
      end
      if (skid_load) begin
        skid_q <= in_pay;
      end
    end
  end

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;

`else

  logic valid_q;
  logic accept;

  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
    end else if (accept && !flush) begin
      head_q <= in_pay;
    end
  end

  assign out_valid = valid_q;

`endif

  assign {out_rd, head_ctrl, out_result, out_wdata} = head_q;
  assign out_ctrl = head_ctrl & {CTRL_W{out_valid}};

  pipe_sat_counter #(
    .WIDTH(STALL_CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid & ~out_ready),
    .count(stall_cnt)
  );

endmodule
